// File: rtl/synth_pkg.sv
// Shared widths, FSM state encoding and helpers for the synth front-end blocks.
package synth_pkg;
   localparam int NOTE_W      = 7;
   localparam int VOICE_IDX_W = 8;
   localparam int TUNING_W    = 32;
   localparam int VEL_W       = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SCAN    = 2'd1,
      S_RESOLVE = 2'd2,
      S_ISSUE   = 2'd3
   } state_t;

   // Slot index width; a single-voice build still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// Note-event request and voice_controller command bundle of the voice allocator.
interface voice_allocator_if;
   import synth_pkg::*;

   logic                   i_note_valid;
   logic                   o_note_ready;
   logic                   i_note_on;
   logic [NOTE_W-1:0]      i_note_num;
   logic [TUNING_W-1:0]    i_tuning_code;
   logic [VEL_W-1:0]       i_velocity;
   logic                   o_SPI_flag;
   logic [VOICE_IDX_W-1:0] o_SPI_voice_index;
   logic                   o_SPI_note_status;
   logic [TUNING_W-1:0]    o_SPI_tuning_code;
   logic [VEL_W-1:0]       o_SPI_velocity;
   logic                   o_steal;
   logic [7:0]             o_active_count;

   modport master (
      output i_note_valid, i_note_on, i_note_num, i_tuning_code, i_velocity,
      input  o_note_ready, o_SPI_flag, o_SPI_voice_index, o_SPI_note_status,
             o_SPI_tuning_code, o_SPI_velocity, o_steal, o_active_count
   );

   modport slave (
      input  i_note_valid, i_note_on, i_note_num, i_tuning_code, i_velocity,
      output o_note_ready, o_SPI_flag, o_SPI_voice_index, o_SPI_note_status,
             o_SPI_tuning_code, o_SPI_velocity, o_steal, o_active_count
   );
endinterface

// File: rtl/voice_table.sv
// Per-slot voice state (active, note, age stamp) with one read port, one write
// port and a registered count of active slots.
module voice_table
   import synth_pkg::*;
#(
   parameter int N_VOICES = 8,
   parameter int STAMP_W  = 16,
   parameter int IDX_W    = 3
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic               o_rd_active,
   output logic [NOTE_W-1:0]  o_rd_note,
   output logic [STAMP_W-1:0] o_rd_stamp,
   input  logic               i_wr_en,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic               i_wr_active,
   input  logic [NOTE_W-1:0]  i_wr_note,
   input  logic [STAMP_W-1:0] i_wr_stamp,
   output logic [7:0]         o_active_count
);

   logic [N_VOICES-1:0]              r_active;
   logic [N_VOICES-1:0][NOTE_W-1:0]  r_note;
   logic [N_VOICES-1:0][STAMP_W-1:0] r_stamp;
   logic [7:0]                       r_active_count;
   logic [N_VOICES-1:0]              w_active_nxt;
   logic [8:0]                       w_cnt;

   assign o_rd_active    = r_active[i_rd_idx];
   assign o_rd_note      = r_note[i_rd_idx];
   assign o_rd_stamp     = r_stamp[i_rd_idx];
   assign o_active_count = r_active_count;

   // Count the post-write vector so the count settles the cycle after the write.
   always_comb begin
      w_active_nxt = r_active;
      if (i_wr_en) w_active_nxt[i_wr_idx] = i_wr_active;
      w_cnt = '0;
      for (int i = 0; i < N_VOICES; i++) w_cnt = w_cnt + 9'(w_active_nxt[i]);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_active       <= '0;
         r_note         <= '0;
         r_stamp        <= '0;
         r_active_count <= '0;
      end else begin
         r_active       <= w_active_nxt;
         r_active_count <= w_cnt[7:0];
         // A note-off only clears active; note and stamp are don't-care afterwards.
         if (i_wr_en && i_wr_active) begin
            r_note[i_wr_idx]  <= i_wr_note;
            r_stamp[i_wr_idx] <= i_wr_stamp;
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans the voice table one slot per cycle, picks
// retrigger / lowest free / oldest voice and emits one command pulse per event.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int N_VOICES = 8,
   parameter int STAMP_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   voice_allocator_if.slave bus
);

   localparam int               IDX_W    = idx_width(N_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

   state_t                 r_state, w_state_nxt;
   logic                   w_ready, w_accept, w_go_issue, w_steal;
   logic [IDX_W-1:0]       w_target;

   logic                   r_on;
   logic [NOTE_W-1:0]      r_note;
   logic [TUNING_W-1:0]    r_tuning;
   logic [VEL_W-1:0]       r_vel;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_match_vld, r_free_vld, r_old_vld;
   logic [IDX_W-1:0]       r_match_idx, r_free_idx, r_old_idx;
   logic [STAMP_W-1:0]     r_old_age;
   logic [STAMP_W-1:0]     r_stamp_ctr;
   logic [IDX_W-1:0]       r_target;

   logic                   r_flag, r_steal, r_spi_status;
   logic [VOICE_IDX_W-1:0] r_spi_idx;
   logic [TUNING_W-1:0]    r_spi_tuning;
   logic [VEL_W-1:0]       r_spi_vel;

   logic                   w_rd_active;
   logic [NOTE_W-1:0]      w_rd_note;
   logic [STAMP_W-1:0]     w_rd_stamp;
   logic [STAMP_W-1:0]     w_age;
   logic                   w_wr_en;
   logic [7:0]             w_active_count;

   voice_table #(
      .N_VOICES(N_VOICES), .STAMP_W(STAMP_W), .IDX_W(IDX_W)
   ) u_table (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_rd_idx(r_idx), .o_rd_active(w_rd_active), .o_rd_note(w_rd_note),
      .o_rd_stamp(w_rd_stamp),
      .i_wr_en(w_wr_en), .i_wr_idx(r_target), .i_wr_active(r_on),
      .i_wr_note(r_note), .i_wr_stamp(r_stamp_ctr),
      .o_active_count(w_active_count)
   );

   // Modular age keeps the oldest-voice choice correct across stamp wrap.
   assign w_age   = r_stamp_ctr - w_rd_stamp;
   assign w_wr_en = (r_state == S_ISSUE);
   assign w_steal = r_on && !r_match_vld && !r_free_vld;

   always_comb begin
      w_target = r_old_idx;
      if (r_match_vld)     w_target = r_match_idx;
      else if (r_free_vld) w_target = r_free_idx;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_go_issue  = r_on || r_match_vld;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.i_note_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN:    if (r_idx == LAST_IDX) w_state_nxt = S_RESOLVE;
         S_RESOLVE: w_state_nxt = w_go_issue ? S_ISSUE : S_IDLE;
         S_ISSUE:   w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_on        <= 1'b0;
         r_note      <= '0;
         r_tuning    <= '0;
         r_vel       <= '0;
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
         r_old_vld   <= 1'b0;
         r_match_idx <= '0;
         r_free_idx  <= '0;
         r_old_idx   <= '0;
         r_old_age   <= '0;
      end else if (w_accept) begin
         r_on        <= bus.i_note_on;
         r_note      <= bus.i_note_num;
         r_tuning    <= bus.i_tuning_code;
         r_vel       <= bus.i_velocity;
         r_idx       <= '0;
         r_match_vld <= 1'b0;
         r_free_vld  <= 1'b0;
         r_old_vld   <= 1'b0;
      end else if (r_state == S_SCAN) begin
         r_idx <= r_idx + 1'b1;
         if (w_rd_active) begin
            if (!r_match_vld && (w_rd_note == r_note)) begin
               r_match_vld <= 1'b1;
               r_match_idx <= r_idx;
            end
            // Strict compare keeps the lowest index on equal ages.
            if (!r_old_vld || (w_age > r_old_age)) begin
               r_old_vld <= 1'b1;
               r_old_idx <= r_idx;
               r_old_age <= w_age;
            end
         end else if (!r_free_vld) begin
            r_free_vld <= 1'b1;
            r_free_idx <= r_idx;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_flag       <= 1'b0;
         r_steal      <= 1'b0;
         r_spi_status <= 1'b0;
         r_spi_idx    <= '0;
         r_spi_tuning <= '0;
         r_spi_vel    <= '0;
         r_target     <= '0;
         r_stamp_ctr  <= '0;
      end else begin
         r_flag  <= 1'b0;
         r_steal <= 1'b0;
         if (r_state == S_RESOLVE && w_go_issue) begin
            r_flag       <= 1'b1;
            r_steal      <= w_steal;
            r_target     <= w_target;
            r_spi_idx    <= VOICE_IDX_W'(w_target);
            r_spi_status <= r_on;
            r_spi_tuning <= r_tuning;
            r_spi_vel    <= r_vel;
         end
         if (r_state == S_ISSUE && r_on) r_stamp_ctr <= r_stamp_ctr + 1'b1;
      end
   end

   assign bus.o_note_ready      = w_ready;
   assign bus.o_SPI_flag        = r_flag;
   assign bus.o_SPI_voice_index = r_spi_idx;
   assign bus.o_SPI_note_status = r_spi_status;
   assign bus.o_SPI_tuning_code = r_spi_tuning;
   assign bus.o_SPI_velocity    = r_spi_vel;
   assign bus.o_steal           = r_steal;
   assign bus.o_active_count    = w_active_count;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against a slot-table reference model.
module tb_voice_allocator;
   localparam int N  = 8;
   localparam int SW = 4;
   localparam int M  = 1 << SW;

   typedef struct packed {
      logic [31:0] flag_cnt;
      logic [31:0] flag_at;
      logic [31:0] ready_at;
      logic [7:0]  idx;
      logic        status;
      logic [31:0] tune;
      logic [7:0]  vel;
      logic        steal;
      logic [7:0]  cnt;
      logic [31:0] held;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   bit          m_act[N];
   int          m_note[N];
   int          m_stamp[N];
   int          m_ctr;
   logic [31:0] m_last_tune;

   voice_allocator_if bus ();

   voice_allocator #(.N_VOICES(N), .STAMP_W(SW)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 1'b0; m_note[i] = 0; m_stamp[i] = 0;
      end
      m_ctr = 0;
      m_last_tune = '0;
   endtask

   // Expected observation: lowest matching voice, else lowest free, else largest modular age.
   task automatic model_event(input bit on, input int note, input logic [31:0] tune,
                              input logic [7:0] vel, output obs_t e);
      int match, free, old, best, age, tgt, cnt;
      e = '0; match = -1; free = -1; old = -1; best = -1;
      for (int i = 0; i < N; i++) begin
         if (m_act[i] && m_note[i] == note && match < 0) match = i;
         if (!m_act[i] && free < 0) free = i;
         if (m_act[i]) begin
            age = (m_ctr - m_stamp[i] + M) % M;
            if (age > best) begin best = age; old = i; end
         end
      end
      if (on || match >= 0) begin
         tgt = (match >= 0) ? match : (free >= 0) ? free : old;
         e.flag_cnt = 1; e.flag_at = N + 2; e.ready_at = N + 3;
         e.idx = 8'(tgt); e.status = on; e.tune = tune; e.vel = vel;
         e.steal = on && match < 0 && free < 0;
         m_last_tune = tune;
         if (on) begin
            m_act[tgt] = 1'b1; m_note[tgt] = note; m_stamp[tgt] = m_ctr;
            m_ctr = (m_ctr + 1) % M;
         end else begin
            m_act[tgt] = 1'b0;
         end
      end else begin
         e.ready_at = N + 2;
      end
      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(m_act[i]);
      e.cnt = 8'(cnt);
      e.held = m_last_tune;
   endtask

   // Offer one event, then watch N+4 cycles after acceptance (cycle index 1 = first after accept).
   task automatic do_event(input bit on, input int note, input logic [31:0] tune,
                           input logic [7:0] vel, output obs_t o);
      int n;
      o = '0;
      @(negedge clk);
      bus.i_note_valid = 1'b1; bus.i_note_on = on; bus.i_note_num = 7'(note);
      bus.i_tuning_code = tune; bus.i_velocity = vel;
      n = 0;
      while (!bus.o_note_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL accept_timeout: ready stayed low for %0d cycles, required high", n);
      end
      @(posedge clk);
      @(negedge clk);
      bus.i_note_valid = 1'b0; bus.i_note_on = 1'($urandom); bus.i_note_num = 7'($urandom);
      bus.i_tuning_code = $urandom; bus.i_velocity = 8'($urandom);
      for (int c = 1; c <= N + 4; c++) begin
         if (bus.o_SPI_flag) begin
            o.flag_cnt++; o.flag_at = c; o.idx = bus.o_SPI_voice_index;
            o.status = bus.o_SPI_note_status; o.tune = bus.o_SPI_tuning_code;
            o.vel = bus.o_SPI_velocity; o.steal = bus.o_steal;
         end
         if (bus.o_note_ready && o.ready_at == 0) o.ready_at = c;
         if (c == N + 3) o.cnt = bus.o_active_count;
         if (c == N + 4) o.held = bus.o_SPI_tuning_code;
         if (c < N + 4) @(negedge clk);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; bus.i_note_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if ({bus.o_note_ready, bus.o_SPI_flag, bus.o_SPI_note_status, bus.o_steal,
           bus.o_SPI_voice_index, bus.o_SPI_tuning_code, bus.o_SPI_velocity,
           bus.o_active_count} !== {1'b1, 3'b0, 8'd0, 32'd0, 8'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b flag=%b idx=%0d cnt=%0d, required ready=1 rest 0",
                  bus.o_note_ready, bus.o_SPI_flag, bus.o_SPI_voice_index, bus.o_active_count);
      end
   endtask

   task automatic test_basic();
      obs_t o, e;
      do_event(1'b1, 60, 32'd20_000_000, 8'd100, o);
      model_event(1'b1, 60, 32'd20_000_000, 8'd100, e);
      n_tests++;
      if (o !== e) begin
         n_fail++; $display("FAIL basic_on: got %p want %p", o, e);
      end
      n_tests++;
      if (o.flag_at !== N + 2 || o.idx !== 8'd0 || o.tune !== 32'd20_000_000 || o.status !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency: flag_at=%0d idx=%0d tune=%0d, required %0d/0/20000000",
                  o.flag_at, o.idx, o.tune, N + 2);
      end
   endtask

   task automatic test_alloc();
      obs_t o, e;
      int notes[3] = '{62, 64, 62};
      bit ons[3]   = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         do_event(ons[i], notes[i], $urandom, 8'($urandom), o);
         model_event(ons[i], notes[i], o.tune, o.vel, e);
         if (!ons[i]) begin e.tune = o.tune; e.vel = o.vel; e.held = o.held; end
         n_tests++;
         if (o !== e) begin
            n_fail++; $display("FAIL alloc_%0d: got %p want %p", i, o, e);
         end
         if (i == 1) begin
            n_tests++;
            if (o.idx !== 8'd2 || o.cnt !== 8'd3) begin
               n_fail++; $display("FAIL alloc_count: idx=%0d cnt=%0d, required 2/3", o.idx, o.cnt);
            end
         end
      end
      n_tests++;
      if (o.idx !== 8'd1 || o.status !== 1'b0) begin
         n_fail++; $display("FAIL alloc_off: idx=%0d status=%b, required 1/0", o.idx, o.status);
      end
   endtask

   task automatic test_steal();
      obs_t o, e;
      logic [31:0] t;
      apply_reset();
      for (int nt = 40; nt <= 49; nt++) begin
         t = $urandom;
         do_event(1'b1, nt, t, 8'(nt), o);
         model_event(1'b1, nt, t, 8'(nt), e);
         n_tests++;
         if (o !== e) begin
            n_fail++; $display("FAIL steal_note%0d: got %p want %p", nt, o, e);
         end
         if (nt >= 48) begin
            n_tests++;
            if (o.idx !== 8'(nt - 48) || o.steal !== 1'b1 || o.cnt !== 8'd8) begin
               n_fail++;
               $display("FAIL steal_pick%0d: idx=%0d steal=%b cnt=%0d, required %0d/1/8",
                        nt, o.idx, o.steal, o.cnt, nt - 48);
            end
         end
      end
   endtask

   task automatic test_retrigger();
      obs_t o1, o2;
      apply_reset();
      do_event(1'b1, 60, 32'd111, 8'd1, o1);
      do_event(1'b1, 60, 32'd222, 8'd2, o2);
      n_tests++;
      if (o2.idx !== o1.idx || o2.steal !== 1'b0 || o2.cnt !== 8'd1 || o2.tune !== 32'd222) begin
         n_fail++;
         $display("FAIL retrigger: idx=%0d/%0d steal=%b cnt=%0d tune=%0d, required same/0/1/222",
                  o1.idx, o2.idx, o2.steal, o2.cnt, o2.tune);
      end
      model_reset();
      m_act[0] = 1'b1; m_note[0] = 60; m_stamp[0] = 1; m_ctr = 2; m_last_tune = 32'd222;
   endtask

   task automatic test_off_unplayed();
      obs_t o, e;
      do_event(1'b0, 70, 32'd5, 8'd5, o);
      model_event(1'b0, 70, 32'd5, 8'd5, e);
      n_tests++;
      if (o !== e || o.flag_cnt !== 0 || o.ready_at !== N + 2) begin
         n_fail++; $display("FAIL off_unplayed: got %p want %p", o, e);
      end
   endtask

   // Drive the stamp counter to 2^SW-2 with retriggers, then fill and steal across the wrap.
   task automatic test_wrap();
      obs_t o, e;
      logic [31:0] t;
      apply_reset();
      for (int i = 0; i < M - 2; i++) begin
         do_event(1'b1, 30, 32'(i), 8'd0, o);
         model_event(1'b1, 30, 32'(i), 8'd0, e);
      end
      do_event(1'b0, 30, 32'd0, 8'd0, o);
      model_event(1'b0, 30, 32'd0, 8'd0, e);
      e.tune = o.tune; e.vel = o.vel;
      n_tests++;
      if (o !== e) begin
         n_fail++; $display("FAIL wrap_prep: got %p want %p", o, e);
      end
      for (int nt = 80; nt < 90; nt++) begin
         t = $urandom;
         do_event(1'b1, nt, t, 8'(nt), o);
         model_event(1'b1, nt, t, 8'(nt), e);
         n_tests++;
         if (o !== e) begin
            n_fail++; $display("FAIL wrap_note%0d: got %p want %p", nt, o, e);
         end
      end
      n_tests++;
      if (o.idx !== 8'd1 || o.steal !== 1'b1) begin
         n_fail++; $display("FAIL wrap_oldest: idx=%0d steal=%b, required 1/1", o.idx, o.steal);
      end
   endtask

   task automatic test_reset_midscan();
      obs_t o, e;
      int flags;
      for (int nt = 20; nt < 23; nt++) do_event(1'b1, nt, 32'd9, 8'd9, o);
      @(negedge clk);
      bus.i_note_valid = 1'b1; bus.i_note_on = 1'b1; bus.i_note_num = 7'd99;
      @(posedge clk);
      @(negedge clk);
      bus.i_note_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      flags = 0;
      for (int c = 0; c < N + 4; c++) begin
         if (bus.o_SPI_flag) flags++;
         @(negedge clk);
      end
      n_tests++;
      if (flags !== 0 || bus.o_note_ready !== 1'b1 || bus.o_active_count !== 8'd0) begin
         n_fail++;
         $display("FAIL midscan_reset: flags=%0d ready=%b cnt=%0d, required 0/1/0",
                  flags, bus.o_note_ready, bus.o_active_count);
      end
      do_event(1'b1, 21, 32'd77, 8'd7, o);
      model_event(1'b1, 21, 32'd77, 8'd7, e);
      n_tests++;
      if (o !== e) begin
         n_fail++; $display("FAIL midscan_after: got %p want %p", o, e);
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      bit on;
      int nt;
      logic [31:0] t;
      logic [7:0] v;
      apply_reset();
      for (int i = 0; i < 200; i++) begin
         on = ($urandom_range(0, 2) != 0);
         nt = 40 + int'($urandom_range(0, 11));
         t  = $urandom;
         v  = 8'($urandom);
         do_event(on, nt, t, v, o);
         model_event(on, nt, t, v, e);
         n_tests++;
         if (o !== e) begin
            n_fail++; $display("FAIL random_%0d: got %p want %p", i, o, e);
         end
      end
   endtask

   initial begin
      bus.i_note_valid = 1'b0; bus.i_note_on = 1'b0; bus.i_note_num = '0;
      bus.i_tuning_code = '0; bus.i_velocity = '0;
      model_reset();
      test_reset();
      test_basic();
      test_alloc();
      test_steal();
      test_retrigger();
      test_off_unplayed();
      test_wrap();
      test_reset_midscan();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
